// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and mode encodings for the pipelined carry-lookahead adder.
package pipelined_cla_adder_pkg;

    localparam int unsigned GroupWidth = 4;

    typedef enum logic {
        ModeAdd = 1'b0,
        ModeSub = 1'b1
    } mode_e;

endpackage

// File: rtl/pipelined_cla_adder_cla_group4.sv
// Combinational 4-bit carry-lookahead group with group propagate/generate outputs.
module cla_group4
    import pipelined_cla_adder_pkg::*;
(
    input  logic [GroupWidth-1:0] a,
    input  logic [GroupWidth-1:0] b,
    input  logic                  ci,
    output logic [GroupWidth-1:0] s,
    output logic                  co,
    output logic                  gp,
    output logic                  gg,
    output logic                  c3
);

    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;

    assign p = a ^ b;
    assign g = a & b;

    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign gp = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign co = gg | (gp & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/pipelined_cla_adder.sv
// Add/subtract unit resolving one 4-bit lookahead group per pipeline stage,
// with a global valid/ready stall.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int unsigned GROUPS = WIDTH / GroupWidth;

    if ((WIDTH % GroupWidth) != 0 || WIDTH < GroupWidth) begin : g_width_check
        $error("WIDTH must be a non-zero multiple of 4");
    end

    // Rank 0 holds the accepted operands; rank k+1 holds the beat after group k resolved.
    logic [GROUPS:0]  vld_q;
    logic [WIDTH-1:0] a_q   [GROUPS+1];
    logic [WIDTH-1:0] bp_q  [GROUPS+1];
    logic [WIDTH-1:0] sum_q [GROUPS+1];
    logic             c_q   [GROUPS+1];
    logic             c_msb_q;

    logic [WIDTH-1:0]      sum_d  [GROUPS];
    logic                  carry_d[GROUPS];
    logic [GroupWidth-1:0] grp_s  [GROUPS];
    logic                  grp_co [GROUPS];
    logic                  grp_gp [GROUPS];
    logic                  grp_gg [GROUPS];
    logic                  grp_c3 [GROUPS];

    mode_e mode;
    logic  en;

    assign mode = mode_e'(sub);
    assign en   = out_ready | ~vld_q[GROUPS];

    for (genvar g = 0; g < GROUPS; g++) begin : g_grp
        cla_group4 u_grp (
            .a  (a_q[g][g*GroupWidth +: GroupWidth]),
            .b  (bp_q[g][g*GroupWidth +: GroupWidth]),
            .ci (c_q[g]),
            .s  (grp_s[g]),
            .co (grp_co[g]),
            .gp (grp_gp[g]),
            .gg (grp_gg[g]),
            .c3 (grp_c3[g])
        );
    end

    // Between stages the carry comes from the group G/P pair; the last group's co drives Cout.
    always_comb begin
        for (int unsigned k = 0; k < GROUPS; k++) begin
            sum_d[k] = sum_q[k];
            sum_d[k][k*GroupWidth +: GroupWidth] = grp_s[k];
            if (k == GROUPS - 1) begin
                carry_d[k] = grp_co[k];
            end else begin
                carry_d[k] = grp_gg[k] | (grp_gp[k] & c_q[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            c_msb_q <= 1'b0;
            for (int unsigned k = 0; k <= GROUPS; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                sum_q[k] <= '0;
                c_q[k]   <= 1'b0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            a_q[0]   <= a;
            bp_q[0]  <= (mode == ModeSub) ? ~b : b;
            c_q[0]   <= (mode == ModeSub) ? ~cin : cin;
            sum_q[0] <= '0;
            for (int unsigned k = 0; k < GROUPS; k++) begin
                vld_q[k+1] <= vld_q[k];
                a_q[k+1]   <= a_q[k];
                bp_q[k+1]  <= bp_q[k];
                sum_q[k+1] <= sum_d[k];
                c_q[k+1]   <= carry_d[k];
            end
            c_msb_q <= grp_c3[GROUPS-1];
        end
    end

    assign in_ready  = en;
    assign out_valid = vld_q[GROUPS];
    assign sum       = sum_q[GROUPS];
    assign Cout      = c_q[GROUPS];
    assign ovf       = c_msb_q ^ c_q[GROUPS];

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH = 16) against an arithmetic reference queue.
module tb_pipelined_cla_adder;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         Cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   acc;
    int   sent;

    always #5 clk = ~clk;

    pipelined_cla_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .Cout      (Cout),
        .ovf       (ovf)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t        m;
        logic [W:0]  full;
        if (!s) begin
            full   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
            m.cout = full[W];
            m.ovf  = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
        end else begin
            full   = {1'b0, x} - {1'b0, y} - (W+1)'(c);
            m.cout = ~full[W];
            m.ovf  = (x[W-1] != y[W-1]) && (full[W-1] != x[W-1]);
        end
        m.sum = full[W-1:0];
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: judge handshakes mid-cycle, then return just after the next rising edge.
    task automatic cycle();
        @(negedge clk);
        acc = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    chk("sum", 32'(sum), 32'(q[0].sum));
                    chk("cout", 32'(Cout), 32'(q[0].cout));
                    chk("ovf", 32'(ovf), 32'(q[0].ovf));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                q.push_back(model(a, b, cin, sub));
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        chk("drain_empty", 32'(q.size()), 32'd0);
        for (int i = 0; i < 6; i++) cycle();
    endtask

    task automatic send_expect(input logic [W-1:0] xa, input logic [W-1:0] xb,
                               input logic xc, input logic xs, input logic [W-1:0] esum,
                               input logic ec, input logic eo);
        out_ready = 1'b1;
        a = xa; b = xb; cin = xc; sub = xs;
        in_valid = 1'b1;
        cycle();
        chk("accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("latency_not_yet", 32'(out_valid), 32'd0);
            cycle();
        end
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("dir_sum", 32'(sum), 32'(esum));
        chk("dir_cout", 32'(Cout), 32'(ec));
        chk("dir_ovf", 32'(ovf), 32'(eo));
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(Cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        cycle();

        send_expect(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_expect(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_expect(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_expect(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();

        // Back-to-back stream with full throughput after the fill.
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            in_valid = 1'b1;
            cycle();
            chk("stream_accept", 32'(acc), 32'd1);
            if (i >= 4) chk("stream_throughput", 32'(out_valid), 32'd1);
        end
        drain();

        // Ten-cycle output stall in the middle of a stream.
        sent = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 8 && c < 18);
            if (!in_valid && sent < 30) begin
                rand_ops();
                in_valid = 1'b1;
            end
            #1;
            if (c >= 8 && c < 18) chk("stall_in_ready", 32'(in_ready), 32'd0);
            cycle();
            if (acc) begin
                sent++;
                if (sent < 30) rand_ops();
                else in_valid = 1'b0;
            end
        end
        chk("stall_beats_sent", 32'(sent), 32'd30);
        drain();

        // Random bubbles and backpressure.
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(0, 9) < 6);
            in_valid  = ($urandom_range(0, 9) < 7);
            rand_ops();
            cycle();
        end
        drain();

        // Reset with three beats in flight; none may emerge.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("midrst_no_emerge", 32'(out_valid), 32'd0);
        end

        // Accept after reset behaves as from idle.
        send_expect(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 Parameter GROUPS, derived as WIDTH/4, the number of 4-bit lookahead groups and pipeline stages; SHALL not be overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts a beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result beat present.
REQ-012 out_ready  input  1  downstream accepts the result beat.
REQ-013 sum  output  WIDTH  result.
REQ-014 Cout  output  1  carry-out of the final group.
REQ-015 ovf  output  1  two's-complement signed overflow flag.

Function
REQ-016 Effective operands SHALL be B' = sub ? ~b : b and C0 = sub ? ~cin : cin; result = a + B' + C0 mod 2^WIDTH.
REQ-017 Subtract SHALL yield sum = a - b - cin; Cout = 1 means no borrow.
REQ-018 Each group SHALL compute P = a^B' and G = a&B' per bit, a full 4-bit lookahead carry chain, and group-level propagate and generate signals.
REQ-019 Stage k (0..GROUPS-1) SHALL resolve group k using the carry registered from stage k-1; stage 0 uses C0.
REQ-020 The operand bits of higher groups SHALL be skewed through delay registers so that group k's bits reach stage k together with its carry.
REQ-021 The lower sum nibbles SHALL be carried forward, so that all nibbles of one beat appear together at the output.
REQ-022 Latency SHALL be exactly GROUPS cycles from the accepting edge to the first cycle with out_valid = 1, with no stall in between.
REQ-023 Throughput SHALL be one beat per cycle while out_ready = 1.
REQ-024 ovf SHALL equal the carry into the MSB XOR Cout, registered with its beat.
REQ-025 A beat is accepted when in_valid & in_ready = 1; a result is consumed when out_valid & out_ready = 1.
REQ-026 in_ready SHALL be out_ready | ~out_valid, a global stall with no combinational path from in_valid.
REQ-027 While stalled (in_ready = 0), every stage register and valid bit SHALL hold, and sum/Cout/ovf SHALL stay stable while out_valid = 1.
REQ-028 Bubbles (in_valid = 0 while in_ready = 1) SHALL propagate as invalid stages.
REQ-029 Under a stall, a bubble stage SHALL NOT be filled early, so ordering is preserved.
REQ-030 No beat SHALL be lost, duplicated or reordered under any in_valid/out_ready pattern.
REQ-031 A simultaneous accept and consume in the same cycle SHALL both take effect.

Reset
REQ-032 While rst = 1, all stage valid bits SHALL clear, out_valid = 0, sum = 0, Cout = 0, ovf = 0.
REQ-033 While rst = 1, in_ready SHALL follow REQ-026 and therefore read 1.
REQ-034 Beats in flight at reset SHALL be discarded, even when rst asserts mid-stream or during a stall.
REQ-035 No accept SHALL occur on an edge where rst = 1.
REQ-036 The first accept after rst deasserts SHALL behave as from the idle state.

Structure
REQ-037 A shared package SHALL hold the group width constant (4) and the mode encodings ADD = 0 and SUB = 1.
REQ-038 One sub-module, cla_group4, SHALL implement the combinational 4-bit lookahead group.
REQ-039 cla_group4 inputs SHALL be a[3:0], b[3:0] and ci; outputs SHALL be s[3:0], co, gp, gg and c3 (carry into bit 3).
REQ-040 The top level SHALL instantiate GROUPS copies of cla_group4 plus the pipeline and skew registers.

Verification (WIDTH = 16)
REQ-041 Add: a = 0xFFFF, b = 0x0001, cin = 0 -> sum = 0x0000, Cout = 1, ovf = 0, out_valid exactly 4 cycles after accept.
REQ-042 Subtract: a = 0x0005, b = 0x0007, cin = 0, sub = 1 -> sum = 0xFFFE, Cout = 0, ovf = 0.
REQ-043 Signed overflow: a = 0x7FFF, b = 0x0001, add -> sum = 0x8000, ovf = 1, Cout = 0; a = 0x8000, b = 0x0001, sub -> sum = 0x7FFF, ovf = 1.
REQ-044 Streaming: 100 back-to-back random beats, out_ready = 1 -> 100 results in order, one per cycle after the 4-cycle fill, all matching a reference model.
REQ-045 Backpressure: a stream with out_ready = 0 for 10 cycles -> in_ready = 0 while out_valid = 1, outputs stable, no loss or duplication, correct order on resume.
REQ-046 Reset mid-operation: rst = 1 for 1 cycle with 3 beats in flight -> out_valid = 0 next cycle and none of those 3 beats ever emerge.
